// File: rtl/quad_decoder.sv
// Quadrature receiver: synchronises and deglitches the A/B phases, decodes 4x,
// and accumulates a signed position with illegal-transition flagging.
module quad_decoder #(
  parameter int unsigned FILTER_LEN = 4,
  parameter int unsigned CNT_W      = 8,
  parameter bit          SATURATE   = 1'b1
) (
  input  logic                    CLK,
  input  logic                    Reset_n,
  input  logic                    quad_a,
  input  logic                    quad_b,
  input  logic                    clr,
  output logic signed [CNT_W-1:0] pos,
  output logic                    step,
  output logic                    dir,
  output logic                    err,
  output logic [7:0]              err_cnt
);

  localparam int unsigned FcW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FcW-1:0] FcMax = FcW'(FILTER_LEN - 1);

  localparam logic signed [CNT_W-1:0] PosMax = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic signed [CNT_W-1:0] PosMin = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic signed [CNT_W-1:0] PosOne = CNT_W'(1);

  // Phase vectors are {A, B}: bit 1 is A, bit 0 is B.
  logic [1:0]     sync1_q, sync2_q;
  logic [FcW-1:0] fcnt_q [2];
  logic [FcW-1:0] fcnt_d [2];
  logic [1:0]     filt_q, filt_d;
  logic [1:0]     filt_prev_q;

  logic           primed_q, primed_d;
  logic [FcW-1:0] prime_cnt_q, prime_cnt_d;
  logic           quiet;

  logic signed [CNT_W-1:0] pos_q, pos_d;
  logic                    step_q, step_d;
  logic                    dir_q, dir_d;
  logic                    err_q, err_d;
  logic [7:0]              err_cnt_q, err_cnt_d;

  logic [1:0] idx_prev, idx_cur, delta;

  // Per-phase deglitch: a new level must persist FILTER_LEN cycles at sync2.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < 2; i++) begin
      fcnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == FcMax) begin
          filt_d[i] = sync2_q[i];
        end else begin
          fcnt_d[i] = fcnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Priming absorbs the first filtered level after reset without decoding it.
  always_comb begin
    primed_d    = primed_q;
    prime_cnt_d = prime_cnt_q;
    quiet       = (sync1_q == sync2_q) && (sync2_q == filt_q);
    if (!primed_q) begin
      if (filt_q != filt_prev_q) begin
        primed_d = 1'b1;
      end else if (quiet) begin
        if (prime_cnt_q == FcMax) begin
          primed_d = 1'b1;
        end else begin
          prime_cnt_d = prime_cnt_q + 1'b1;
        end
      end else begin
        prime_cnt_d = '0;
      end
    end
  end

  // Gray state mapped to its position in the forward cycle 00,10,11,01.
  always_comb begin
    idx_prev = {filt_prev_q[0], filt_prev_q[1] ^ filt_prev_q[0]};
    idx_cur  = {filt_q[0], filt_q[1] ^ filt_q[0]};
    delta    = idx_cur - idx_prev;
  end

  always_comb begin
    pos_d     = pos_q;
    step_d    = 1'b0;
    dir_d     = dir_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    if (primed_q) begin
      unique case (delta)
        2'd1: begin
          step_d = 1'b1;
          dir_d  = 1'b1;
          pos_d  = (SATURATE && pos_q == PosMax) ? pos_q : pos_q + PosOne;
        end
        2'd3: begin
          step_d = 1'b1;
          dir_d  = 1'b0;
          pos_d  = (SATURATE && pos_q == PosMin) ? pos_q : pos_q - PosOne;
        end
        2'd2: begin
          err_d = 1'b1;
          if (err_cnt_q != 8'hff) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
    if (clr) begin
      pos_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      fcnt_q[0]   <= '0;
      fcnt_q[1]   <= '0;
      filt_q      <= '0;
      filt_prev_q <= '0;
      primed_q    <= 1'b0;
      prime_cnt_q <= '0;
      pos_q       <= '0;
      step_q      <= 1'b0;
      dir_q       <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      sync1_q     <= {quad_a, quad_b};
      sync2_q     <= sync1_q;
      fcnt_q[0]   <= fcnt_d[0];
      fcnt_q[1]   <= fcnt_d[1];
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      primed_q    <= primed_d;
      prime_cnt_q <= prime_cnt_d;
      pos_q       <= pos_d;
      step_q      <= step_d;
      dir_q       <= dir_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign pos     = pos_q;
  assign step    = step_q;
  assign dir     = dir_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;

`ifndef SYNTHESIS
  step_err_exclusive: assert property (@(posedge CLK) disable iff (!Reset_n) !(step_q && err_q));
`endif

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: directed scenarios plus randomized moves, checked
// against a sequence-position model of the wheel (saturating and wrapping DUTs).
module tb_quad_decoder;

  localparam int CntW   = 8;
  localparam int PosMax = 2 ** (CntW - 1) - 1;
  localparam int PosMin = -(2 ** (CntW - 1));
  localparam logic [1:0] FwdSeq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  logic CLK = 1'b0;
  logic Reset_n = 1'b1;
  logic quad_a = 1'b0;
  logic quad_b = 1'b0;
  logic clr = 1'b0;

  logic signed [CntW-1:0] pos_s, pos_w;
  logic step_s, dir_s, err_s, step_w, dir_w, err_w;
  logic [7:0] err_cnt_s, err_cnt_w;

  int n_tests = 0;
  int n_fail  = 0;
  int step_seen = 0, step_seen_w = 0, err_seen = 0, err_seen_w = 0;

  // Reference model state
  logic [1:0] m_ab;
  int m_pos_sat, m_pos_wrap, m_err_cnt, m_steps, m_errs;
  logic m_dir;

  always #5 CLK = ~CLK;

  quad_decoder #(.FILTER_LEN(4), .CNT_W(CntW), .SATURATE(1'b1)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .quad_a(quad_a), .quad_b(quad_b), .clr(clr),
    .pos(pos_s), .step(step_s), .dir(dir_s), .err(err_s), .err_cnt(err_cnt_s)
  );

  quad_decoder #(.FILTER_LEN(4), .CNT_W(CntW), .SATURATE(1'b0)) dut_w (
    .CLK(CLK), .Reset_n(Reset_n), .quad_a(quad_a), .quad_b(quad_b), .clr(clr),
    .pos(pos_w), .step(step_w), .dir(dir_w), .err(err_w), .err_cnt(err_cnt_w)
  );

  always @(negedge CLK) begin
    if (step_s) step_seen++;
    if (step_w) step_seen_w++;
    if (err_s) err_seen++;
    if (err_w) err_seen_w++;
  end

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int seq_pos(input logic [1:0] ab);
    for (int i = 0; i < 4; i++) if (FwdSeq[i] == ab) return i;
    return 0;
  endfunction

  function automatic int wrap(input int v);
    return ((v - PosMin) % 256 + 256) % 256 + PosMin;
  endfunction

  task automatic model_move(input logic [1:0] nxt);
    int d;
    d = (seq_pos(nxt) - seq_pos(m_ab) + 4) % 4;
    if (d == 1) begin
      m_steps++;
      m_dir = 1'b1;
      if (m_pos_sat < PosMax) m_pos_sat++;
      m_pos_wrap = wrap(m_pos_wrap + 1);
    end else if (d == 3) begin
      m_steps++;
      m_dir = 1'b0;
      if (m_pos_sat > PosMin) m_pos_sat--;
      m_pos_wrap = wrap(m_pos_wrap - 1);
    end else if (d == 2) begin
      m_errs++;
      if (m_err_cnt < 255) m_err_cnt++;
    end
    m_ab = nxt;
  endtask

  task automatic model_reset(input logic [1:0] pins);
    m_ab = pins;
    m_pos_sat = 0;
    m_pos_wrap = 0;
    m_err_cnt = 0;
    m_dir = 1'b0;
  endtask

  task automatic drive(input logic [1:0] ab, input int hold);
    quad_a = ab[1];
    quad_b = ab[0];
    repeat (hold) @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    repeat (10) @(posedge CLK);
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_pos_sat"}, pos_s, m_pos_sat);
    check({tag, "_pos_wrap"}, pos_w, m_pos_wrap);
    check({tag, "_dir"}, dir_s, m_dir);
    check({tag, "_dir_w"}, dir_w, m_dir);
    check({tag, "_err_cnt"}, err_cnt_s, m_err_cnt);
    check({tag, "_err_cnt_w"}, err_cnt_w, m_err_cnt);
    check({tag, "_steps"}, step_seen, m_steps);
    check({tag, "_steps_w"}, step_seen_w, m_steps);
    check({tag, "_errs"}, err_seen, m_errs);
    check({tag, "_errs_w"}, err_seen_w, m_errs);
  endtask

  task automatic apply_reset(input logic [1:0] pins);
    drive(pins, 1);
    Reset_n = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    Reset_n = 1'b1;
    model_reset(pins);
    drive(pins, 20);
  endtask

  initial begin
    int first, steps0, cur, r, g;
    logic [1:0] nxt, mask;
    m_steps = 0;
    m_errs = 0;
    model_reset(2'b11);

    // Reset state and priming with the wheel resting at 11
    #2 Reset_n = 1'b0;
    quad_a = 1'b1;
    quad_b = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_pos", pos_s, 0);
    check("rst_step", step_s, 0);
    check("rst_err", err_s, 0);
    check("rst_err_cnt", err_cnt_s, 0);
    Reset_n = 1'b1;
    drive(2'b11, 20);
    check_all("prime11");

    // Forward cycle with step latency of 7 edges
    apply_reset(2'b00);
    for (int i = 1; i <= 4; i++) begin
      quad_a = FwdSeq[i % 4][1];
      quad_b = FwdSeq[i % 4][0];
      first = 0;
      for (int k = 1; k <= 12; k++) begin
        @(posedge CLK);
        #1;
        if (step_s && first == 0) first = k;
      end
      check("step_latency", first, 7);
      model_move(FwdSeq[i % 4]);
    end
    check_all("fwd4");

    // Reverse twice, then a short glitch on A
    for (int n = 0; n < 8; n++) begin
      nxt = FwdSeq[(seq_pos(m_ab) + 3) % 4];
      drive(nxt, 10);
      model_move(nxt);
    end
    check_all("rev8");
    drive(2'b10, 3);
    drive(2'b00, 12);
    check_all("glitch");

    // Illegal double change, then a normal +1
    drive(2'b11, 10);
    model_move(2'b11);
    check_all("illegal");
    drive(2'b01, 10);
    model_move(2'b01);
    check_all("after_err");

    // Saturation vs wrap over 130 forward steps from zero
    clr = 1'b1;
    @(posedge CLK);
    #1;
    clr = 1'b0;
    m_pos_sat = 0;
    m_pos_wrap = 0;
    steps0 = step_seen;
    for (int n = 0; n < 130; n++) begin
      nxt = FwdSeq[(seq_pos(m_ab) + 1) % 4];
      drive(nxt, 5);
      model_move(nxt);
    end
    settle();
    check("sat_steps130", step_seen - steps0, 130);
    check_all("sat130");

    // clr sampled on the edge a step lands
    nxt = FwdSeq[(seq_pos(m_ab) + 1) % 4];
    drive(nxt, 6);
    clr = 1'b1;
    @(posedge CLK);
    #1;
    clr = 1'b0;
    check("clr_step", step_s, 1);
    model_move(nxt);
    m_pos_sat = 0;
    m_pos_wrap = 0;
    settle();
    check_all("clr_land");

    // Reset asserted while a change is still in the filter
    nxt = FwdSeq[(seq_pos(m_ab) + 1) % 4];
    drive(nxt, 3);
    Reset_n = 1'b0;
    #1;
    check("midrst_pos", pos_s, 0);
    check("midrst_step", step_s, 0);
    check("midrst_dir", dir_s, 0);
    check("midrst_err_cnt", err_cnt_s, 0);
    model_reset(nxt);
    repeat (2) @(posedge CLK);
    #1;
    Reset_n = 1'b1;
    drive(nxt, 20);
    check_all("reprime");

    // Randomized moves, glitches, illegal jumps and clears
    for (int it = 0; it < 80; it++) begin
      r = $urandom_range(0, 9);
      cur = seq_pos(m_ab);
      if (r <= 5) begin
        nxt = ($urandom_range(0, 1) == 1) ? FwdSeq[(cur + 1) % 4] : FwdSeq[(cur + 3) % 4];
        drive(nxt, $urandom_range(4, 9));
        model_move(nxt);
      end else if (r == 6) begin
        nxt = m_ab ^ 2'b11;
        drive(nxt, $urandom_range(4, 9));
        model_move(nxt);
      end else if (r == 7) begin
        mask = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
        g = $urandom_range(1, 3);
        drive(m_ab ^ mask, g);
        drive(m_ab, 4);
      end else if (r == 8) begin
        settle();
        clr = 1'b1;
        @(posedge CLK);
        #1;
        clr = 1'b0;
        m_pos_sat = 0;
        m_pos_wrap = 0;
      end else begin
        settle();
      end
      if (it % 4 == 3) begin
        settle();
        check_all("rand");
      end
    end

    // err_cnt saturates at 255
    for (int n = 0; n < 260; n++) begin
      nxt = m_ab ^ 2'b11;
      drive(nxt, 4);
      model_move(nxt);
    end
    settle();
    check("err_cnt_sat", err_cnt_s, 255);
    check_all("errsat");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
